writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 147 ++++++++++++++
 tb/tb_writeback_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Two-stage MEM/WB back end: EXMEM and MEMWB registers with a small data memory.
// Loads read memory combinationally in MEM; stores commit at the edge that ends MEM.
module writeback_stage #(
  parameter int unsigned DMEM_DEPTH = 256,
  parameter int unsigned DMEM_AW    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ExValid,
  input  logic [15:0] InstructionEX,
  input  logic [31:0] ResultEX,
  input  logic        RegWriteEX,
  input  logic        WriteOP2EX,
  input  logic        MemReadEX,
  input  logic        MemWriteEX,
  input  logic [15:0] StoreDataEX,
  input  logic        Flush,
  output logic [3:0]  WriteReg1,
  output logic [3:0]  WriteReg2,
  output logic [15:0] WriteData1,
  output logic [15:0] WriteData2,
  output logic        RegWrite,
  output logic        WriteOP2,
  output logic        LoadPending,
  output logic [3:0]  LoadReg,
  output logic        Drained
);

  // EXMEM
  logic        ex_valid_q, ex_valid_d;
  logic [3:0]  ex_ra_q, ex_ra_d;
  logic [3:0]  ex_rb_q, ex_rb_d;
  logic [31:0] ex_result_q, ex_result_d;
  logic        ex_rw_q, ex_rw_d;
  logic        ex_op2_q, ex_op2_d;
  logic        ex_mr_q, ex_mr_d;
  logic        ex_mw_q, ex_mw_d;
  logic [15:0] ex_sd_q, ex_sd_d;

  // MEMWB
  logic        wb_valid_q, wb_valid_d;
  logic [3:0]  wb_ra_q, wb_ra_d;
  logic [3:0]  wb_rb_q, wb_rb_d;
  logic [15:0] wb_d1_q, wb_d1_d;
  logic [15:0] wb_d2_q, wb_d2_d;
  logic        wb_rw_q, wb_rw_d;
  logic        wb_op2_q, wb_op2_d;

  logic [15:0]        mem_q [DMEM_DEPTH];
  logic [DMEM_AW-1:0] mem_addr;
  logic [15:0]        mem_rdata;
  logic               mem_we;

  logic unused_instr;
  assign unused_instr = ^{InstructionEX[15:12], InstructionEX[3:0]};

  // Upper result bits are dropped, so addresses wrap modulo the memory depth.
  assign mem_addr  = ex_result_q[DMEM_AW-1:0];
  assign mem_rdata = mem_q[mem_addr];
  // A load wins over a store when both controls are set.
  assign mem_we    = ex_valid_q & ex_mw_q & ~ex_mr_q;

  always_comb begin
    ex_valid_d  = ExValid & ~Flush;
    ex_ra_d     = InstructionEX[11:8];
    ex_rb_d     = InstructionEX[7:4];
    ex_result_d = ResultEX;
    ex_rw_d     = RegWriteEX;
    ex_op2_d    = WriteOP2EX;
    ex_mr_d     = MemReadEX;
    ex_mw_d     = MemWriteEX;
    ex_sd_d     = StoreDataEX;

    wb_valid_d  = ex_valid_q;
    wb_ra_d     = ex_ra_q;
    wb_rb_d     = ex_rb_q;
    wb_d1_d     = ex_result_q[15:0];
    wb_d2_d     = ex_result_q[31:16];
    wb_rw_d     = ex_rw_q;
    wb_op2_d    = ex_op2_q;
    if (ex_mr_q) begin
      wb_d1_d  = mem_rdata;
      wb_d2_d  = '0;
      wb_rw_d  = 1'b1;
      wb_op2_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q  <= 1'b0;
      ex_ra_q     <= '0;
      ex_rb_q     <= '0;
      ex_result_q <= '0;
      ex_rw_q     <= 1'b0;
      ex_op2_q    <= 1'b0;
      ex_mr_q     <= 1'b0;
      ex_mw_q     <= 1'b0;
      ex_sd_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_ra_q     <= '0;
      wb_rb_q     <= '0;
      wb_d1_q     <= '0;
      wb_d2_q     <= '0;
      wb_rw_q     <= 1'b0;
      wb_op2_q    <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_ra_q     <= ex_ra_d;
      ex_rb_q     <= ex_rb_d;
      ex_result_q <= ex_result_d;
      ex_rw_q     <= ex_rw_d;
      ex_op2_q    <= ex_op2_d;
      ex_mr_q     <= ex_mr_d;
      ex_mw_q     <= ex_mw_d;
      ex_sd_q     <= ex_sd_d;
      wb_valid_q  <= wb_valid_d;
      wb_ra_q     <= wb_ra_d;
      wb_rb_q     <= wb_rb_d;
      wb_d1_q     <= wb_d1_d;
      wb_d2_q     <= wb_d2_d;
      wb_rw_q     <= wb_rw_d;
      wb_op2_q    <= wb_op2_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DMEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[mem_addr] <= ex_sd_q;
    end
  end

  assign WriteReg1   = wb_ra_q;
  assign WriteReg2   = wb_rb_q;
  assign WriteData1  = wb_d1_q;
  assign WriteData2  = wb_d2_q;
  assign RegWrite    = wb_valid_q & wb_rw_q;
  assign WriteOP2    = RegWrite & wb_op2_q;
  assign LoadPending = ex_valid_q & ex_mr_q;
  assign LoadReg     = ex_ra_q;
  assign Drained     = ~ex_valid_q & ~wb_valid_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized and directed bench for writeback_stage against an in-order transaction model
// where each accepted instruction applies its memory effect immediately on entry.
module tb_writeback_stage;

  localparam int unsigned Depth = 256;
  localparam int unsigned Aw    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ExValid, RegWriteEX, WriteOP2EX, MemReadEX, MemWriteEX, Flush;
  logic [15:0] InstructionEX, StoreDataEX;
  logic [31:0] ResultEX;
  logic [3:0]  WriteReg1, WriteReg2, LoadReg;
  logic [15:0] WriteData1, WriteData2;
  logic        RegWrite, WriteOP2, LoadPending, Drained;

  always #5 clk = ~clk;

  writeback_stage #(.DMEM_DEPTH(Depth), .DMEM_AW(Aw)) dut (
    .clk          (clk),
    .rst          (rst),
    .ExValid      (ExValid),
    .InstructionEX(InstructionEX),
    .ResultEX     (ResultEX),
    .RegWriteEX   (RegWriteEX),
    .WriteOP2EX   (WriteOP2EX),
    .MemReadEX    (MemReadEX),
    .MemWriteEX   (MemWriteEX),
    .StoreDataEX  (StoreDataEX),
    .Flush        (Flush),
    .WriteReg1    (WriteReg1),
    .WriteReg2    (WriteReg2),
    .WriteData1   (WriteData1),
    .WriteData2   (WriteData2),
    .RegWrite     (RegWrite),
    .WriteOP2     (WriteOP2),
    .LoadPending  (LoadPending),
    .LoadReg      (LoadReg),
    .Drained      (Drained)
  );

  typedef struct {
    bit        v;
    bit        rw;
    bit        op2;
    bit        ld;
    bit [3:0]  r1;
    bit [3:0]  r2;
    bit [15:0] d1;
    bit [15:0] d2;
  } exp_t;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  exp_t        e_mem;  // instruction accepted at the latest edge
  exp_t        e_wb;   // instruction accepted one edge earlier
  bit [15:0]   ref_mem [Depth];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t predict();
    exp_t    e;
    int unsigned a;
    a    = ResultEX % Depth;
    e.v  = ExValid && !Flush;
    e.ld = MemReadEX;
    e.r1 = InstructionEX[11:8];
    e.r2 = InstructionEX[7:4];
    e.d2 = ResultEX[31:16];
    if (MemReadEX) begin
      e.d1  = ref_mem[a];
      e.rw  = 1'b1;
      e.op2 = 1'b0;
    end else begin
      e.d1  = ResultEX[15:0];
      e.rw  = RegWriteEX;
      e.op2 = WriteOP2EX;
      if (e.v && MemWriteEX) ref_mem[a] = StoreDataEX;
    end
    return e;
  endfunction

  task automatic model_reset();
    e_mem = '{default: 0};
    e_wb  = '{default: 0};
    for (int i = 0; i < Depth; i++) ref_mem[i] = '0;
  endtask

  task automatic drive(input bit v, input bit fl, input bit [15:0] ins, input bit [31:0] res,
                       input bit rwe, input bit op2e, input bit mr, input bit mw,
                       input bit [15:0] sd);
    ExValid = v; Flush = fl; InstructionEX = ins; ResultEX = res;
    RegWriteEX = rwe; WriteOP2EX = op2e; MemReadEX = mr; MemWriteEX = mw; StoreDataEX = sd;
  endtask

  task automatic idle();
    drive(0, 0, 16'h0, 32'h0, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic check_outputs();
    bit exp_rw;
    exp_rw = e_wb.v && e_wb.rw;
    check("RegWrite", RegWrite, exp_rw);
    check("WriteOP2", WriteOP2, exp_rw && e_wb.op2);
    if (exp_rw) begin
      check("WriteReg1", WriteReg1, e_wb.r1);
      check("WriteData1", WriteData1, e_wb.d1);
      if (e_wb.op2) begin
        check("WriteReg2", WriteReg2, e_wb.r2);
        check("WriteData2", WriteData2, e_wb.d2);
      end
    end
    check("LoadPending", LoadPending, e_mem.v && e_mem.ld);
    if (e_mem.v && e_mem.ld) check("LoadReg", LoadReg, e_mem.r1);
    check("Drained", Drained, !e_mem.v && !e_wb.v);
  endtask

  // Inputs are already driven; advance one edge and check at the following falling edge.
  task automatic cycle();
    @(posedge clk);
    e_wb  = e_mem;
    e_mem = predict();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    bit [7:0] lo;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_Drained", Drained, 1);
    check("rst_RegWrite", RegWrite, 0);
    check("rst_LoadPending", LoadPending, 0);
    check("rst_WriteData1", WriteData1, 0);
    rst = 1'b1;
    cycle();

    // ADD to r3
    drive(1, 0, 16'h0300, 32'h0000_0005, 1, 0, 0, 0, 16'h0); cycle();
    idle(); cycle();
    check("add_reg", WriteReg1, 3);
    check("add_data", WriteData1, 16'h0005);

    // MUL writing both halves, reg B = 4
    drive(1, 0, 16'h0140, 32'h0001_0002, 1, 1, 0, 0, 16'h0); cycle();
    idle(); cycle();
    check("mul_op2", WriteOP2, 1);
    check("mul_reg2", WriteReg2, 4);
    check("mul_data2", WriteData2, 16'h0001);

    // Store then back-to-back load of the same address
    drive(1, 0, 16'h0000, 32'h0000_0010, 0, 0, 0, 1, 16'hBEEF); cycle();
    drive(1, 0, 16'h0200, 32'h0000_0010, 1, 0, 1, 0, 16'h0); cycle();
    check("ld_pending", LoadPending, 1);
    idle(); cycle();
    check("ld_data", WriteData1, 16'hBEEF);

    // Flushed ADD
    drive(1, 1, 16'h0300, 32'h0000_0005, 1, 0, 0, 0, 16'h0); cycle();
    idle(); cycle();
    check("flush_rw", RegWrite, 0);
    check("flush_drained", Drained, 1);

    // Address wrap, and load+store together leaves memory untouched
    drive(1, 0, 16'h0500, 32'h0000_0110, 1, 0, 1, 0, 16'h0); cycle();
    idle(); cycle();
    check("wrap_data", WriteData1, 16'hBEEF);
    drive(1, 0, 16'h0600, 32'h0000_0010, 1, 0, 1, 1, 16'h1234); cycle();
    drive(1, 0, 16'h0700, 32'h0000_0010, 1, 0, 1, 0, 16'h0); cycle();
    idle(); cycle();
    check("ldst_data", WriteData1, 16'hBEEF);

    // Reset while a load sits in EXMEM
    drive(1, 0, 16'h0700, 32'h0000_0010, 1, 0, 1, 0, 16'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("midrst_Drained", Drained, 1);
    check("midrst_RegWrite", RegWrite, 0);
    idle();
    repeat (2) begin
      @(negedge clk);
      check("midrst_hold_rw", RegWrite, 0);
    end
    rst = 1'b1;
    drive(1, 0, 16'h0800, 32'h0000_0010, 1, 0, 1, 0, 16'h0); cycle();
    idle(); cycle();
    check("postrst_mem", WriteData1, 16'h0000);

    // Random traffic over a few hot addresses so stores and loads collide
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: lo = 8'h10;
        1: lo = 8'h11;
        2: lo = 8'h12;
        default: lo = 8'($urandom);
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 16'($urandom),
            {24'($urandom), lo}, 1'($urandom), 1'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 16'($urandom));
      cycle();
    end
    idle(); cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
